// File: rtl/jtag_tap_param_pkg.sv
// rtl/jtag_tap_param_pkg.sv - TAP state codes, opcode constants and instruction decode

package jtag_tap_param_pkg;

    typedef enum logic [3:0] {
        ST_TLR      = 4'd0,
        ST_RTI      = 4'd1,
        ST_SEL_DR   = 4'd2,
        ST_CAP_DR   = 4'd3,
        ST_SHIFT_DR = 4'd4,
        ST_EXIT1_DR = 4'd5,
        ST_PAUSE_DR = 4'd6,
        ST_EXIT2_DR = 4'd7,
        ST_UPD_DR   = 4'd8,
        ST_SEL_IR   = 4'd9,
        ST_CAP_IR   = 4'd10,
        ST_SHIFT_IR = 4'd11,
        ST_EXIT1_IR = 4'd12,
        ST_PAUSE_IR = 4'd13,
        ST_EXIT2_IR = 4'd14,
        ST_UPD_IR   = 4'd15
    } tap_state_e;

    typedef enum logic [2:0] {
        I_EXTEST,
        I_SAMPLE,
        I_IDCODE,
        I_INTEST,
        I_BYPASS
    } instr_e;

    localparam int unsigned OPC_EXTEST = 0;
    localparam int unsigned OPC_SAMPLE = 1;
    localparam int unsigned OPC_IDCODE = 2;
    localparam int unsigned OPC_INTEST = 3;

    // All-ones is checked first so BYPASS wins when IR_W is too short to keep them apart.
    function automatic instr_e decode_ir(input logic [31:0] ir, input int unsigned ir_w);
        logic [31:0] ones;
        ones = (ir_w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << ir_w) - 32'd1);
        if (ir == ones) begin
            return I_BYPASS;
        end
        case (ir)
            32'(OPC_EXTEST): return I_EXTEST;
            32'(OPC_SAMPLE): return I_SAMPLE;
            32'(OPC_IDCODE): return I_IDCODE;
            32'(OPC_INTEST): return I_INTEST;
            default:         return I_BYPASS;
        endcase
    endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// rtl/jtag_tap_fsm.sv - IEEE 1149.1 TAP controller state machine with phase strobes

module jtag_tap_fsm
    import jtag_tap_param_pkg::*;
(
    input  logic       TCK,
    input  logic       TRST,
    input  logic       TMS,
    output logic [3:0] STATE,
    output logic       capture_dr_o,
    output logic       shift_dr_o,
    output logic       update_dr_o,
    output logic       capture_ir_o,
    output logic       shift_ir_o,
    output logic       update_ir_o,
    output logic       enter_tlr_o
);

    tap_state_e state_q, state_d;

    always_ff @(posedge TCK) begin
        if (TRST) begin
            state_q <= ST_TLR;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_TLR:      state_d = TMS ? ST_TLR      : ST_RTI;
            ST_RTI:      state_d = TMS ? ST_SEL_DR   : ST_RTI;
            ST_SEL_DR:   state_d = TMS ? ST_SEL_IR   : ST_CAP_DR;
            ST_CAP_DR:   state_d = TMS ? ST_EXIT1_DR : ST_SHIFT_DR;
            ST_SHIFT_DR: state_d = TMS ? ST_EXIT1_DR : ST_SHIFT_DR;
            ST_EXIT1_DR: state_d = TMS ? ST_UPD_DR   : ST_PAUSE_DR;
            ST_PAUSE_DR: state_d = TMS ? ST_EXIT2_DR : ST_PAUSE_DR;
            ST_EXIT2_DR: state_d = TMS ? ST_UPD_DR   : ST_SHIFT_DR;
            ST_UPD_DR:   state_d = TMS ? ST_SEL_DR   : ST_RTI;
            ST_SEL_IR:   state_d = TMS ? ST_TLR      : ST_CAP_IR;
            ST_CAP_IR:   state_d = TMS ? ST_EXIT1_IR : ST_SHIFT_IR;
            ST_SHIFT_IR: state_d = TMS ? ST_EXIT1_IR : ST_SHIFT_IR;
            ST_EXIT1_IR: state_d = TMS ? ST_UPD_IR   : ST_PAUSE_IR;
            ST_PAUSE_IR: state_d = TMS ? ST_EXIT2_IR : ST_PAUSE_IR;
            ST_EXIT2_IR: state_d = TMS ? ST_UPD_IR   : ST_SHIFT_IR;
            ST_UPD_IR:   state_d = TMS ? ST_SEL_DR   : ST_RTI;
            default:     state_d = ST_TLR;
        endcase
    end

    assign STATE        = state_q;
    assign capture_dr_o = (state_q == ST_CAP_DR);
    assign shift_dr_o   = (state_q == ST_SHIFT_DR);
    assign update_dr_o  = (state_q == ST_UPD_DR);
    assign capture_ir_o = (state_q == ST_CAP_IR);
    assign shift_ir_o   = (state_q == ST_SHIFT_IR);
    assign update_ir_o  = (state_q == ST_UPD_IR);
    // Looks at the next state so the IR is forced on the same edge that lands in TLR.
    assign enter_tlr_o  = (state_d == ST_TLR);

endmodule

// File: rtl/jtag_tap_param.sv
// rtl/jtag_tap_param.sv - parametrised JTAG TAP with bypass, IDCODE and boundary-scan register

module jtag_tap_param
    import jtag_tap_param_pkg::*;
#(
    parameter int unsigned IR_W       = 4,
    parameter int unsigned N_IN       = 4,
    parameter int unsigned N_OUT      = 2,
    parameter logic [31:0] IDCODE_VAL = 32'h1234_5001
) (
    input  logic             TCK,
    input  logic             TRST,
    input  logic             TMS,
    input  logic             TDI,
    output logic             TDO,
    output logic             TDO_EN,
    output logic [3:0]       STATE,
    input  logic [N_IN-1:0]  sys_in,
    output logic [N_IN-1:0]  core_in,
    input  logic [N_OUT-1:0] core_out,
    output logic [N_OUT-1:0] sys_out
);

    localparam int unsigned     BSR_W      = N_IN + N_OUT;
    localparam logic [IR_W-1:0] IR_IDCODE  = IR_W'(OPC_IDCODE);
    localparam logic [IR_W-1:0] IR_CAPTURE = IR_W'(1);

    logic capture_dr, shift_dr, update_dr;
    logic capture_ir, shift_ir, update_ir;
    logic enter_tlr;

    jtag_tap_fsm u_fsm (
        .TCK          (TCK),
        .TRST         (TRST),
        .TMS          (TMS),
        .STATE        (STATE),
        .capture_dr_o (capture_dr),
        .shift_dr_o   (shift_dr),
        .update_dr_o  (update_dr),
        .capture_ir_o (capture_ir),
        .shift_ir_o   (shift_ir),
        .update_ir_o  (update_ir),
        .enter_tlr_o  (enter_tlr)
    );

    logic [IR_W-1:0]  ir_shift_q, ir_shift_d;
    logic [IR_W-1:0]  ir_active_q, ir_active_d;
    logic             bypass_q, bypass_d;
    logic [31:0]      id_q, id_d;
    logic [BSR_W-1:0] bsr_q, bsr_d;
    logic [BSR_W-1:0] latch_q, latch_d;

    instr_e instr;
    logic   bsr_sel;

    assign instr   = decode_ir(32'(ir_active_q), IR_W);
    assign bsr_sel = (instr == I_EXTEST) || (instr == I_SAMPLE) || (instr == I_INTEST);

    always_comb begin
        ir_shift_d  = ir_shift_q;
        ir_active_d = ir_active_q;
        bypass_d    = bypass_q;
        id_d        = id_q;
        bsr_d       = bsr_q;
        latch_d     = latch_q;

        if (capture_ir) ir_shift_d = IR_CAPTURE;
        if (shift_ir)   ir_shift_d = {TDI, ir_shift_q[IR_W-1:1]};
        if (update_ir)  ir_active_d = ir_shift_q;
        if (enter_tlr)  ir_active_d = IR_IDCODE;

        // Every DR capture reloads all three registers; only the selected one shifts.
        if (capture_dr) begin
            bypass_d = 1'b0;
            id_d     = IDCODE_VAL;
            bsr_d    = {core_out, sys_in};
        end
        if (shift_dr) begin
            case (instr)
                I_BYPASS: bypass_d = TDI;
                I_IDCODE: id_d     = {TDI, id_q[31:1]};
                default:  bsr_d    = {TDI, bsr_q[BSR_W-1:1]};
            endcase
        end
        if (update_dr && bsr_sel) latch_d = bsr_q;
    end

    always_ff @(posedge TCK) begin
        if (TRST) begin
            ir_shift_q  <= '0;
            ir_active_q <= IR_IDCODE;
            bypass_q    <= 1'b0;
            id_q        <= '0;
            bsr_q       <= '0;
            latch_q     <= '0;
        end else begin
            ir_shift_q  <= ir_shift_d;
            ir_active_q <= ir_active_d;
            bypass_q    <= bypass_d;
            id_q        <= id_d;
            bsr_q       <= bsr_d;
            latch_q     <= latch_d;
        end
    end

    always_comb begin
        TDO = 1'b0;
        if (shift_ir) begin
            TDO = ir_shift_q[0];
        end else if (shift_dr) begin
            case (instr)
                I_BYPASS: TDO = bypass_q;
                I_IDCODE: TDO = id_q[0];
                default:  TDO = bsr_q[0];
            endcase
        end
    end

    assign TDO_EN = shift_ir | shift_dr;

    always_comb begin
        core_in = sys_in;
        sys_out = core_out;
        case (instr)
            I_EXTEST: sys_out = latch_q[BSR_W-1:N_IN];
            I_INTEST: begin
                sys_out = latch_q[BSR_W-1:N_IN];
                core_in = latch_q[N_IN-1:0];
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_jtag_tap_param.sv
// tb/tb_jtag_tap_param.sv - directed bench with queue-based TAP model and per-cycle compare

module tb_jtag_tap_param;

    localparam int unsigned IR_W = 4;
    localparam int unsigned N_IN = 4;
    localparam int unsigned N_OUT = 2;
    localparam logic [31:0] IDV = 32'h1234_5001;

    logic       TCK = 1'b0;
    logic       TRST = 1'b1;
    logic       TMS = 1'b1;
    logic       TDI = 1'b0;
    logic       TDO, TDO_EN;
    logic [3:0] STATE;
    logic [3:0] sys_in = 4'b0110;
    logic [3:0] core_in;
    logic [1:0] core_out = 2'b01;
    logic [1:0] sys_out;

    always #5 TCK = ~TCK;

    jtag_tap_param #(
        .IR_W       (IR_W),
        .N_IN       (N_IN),
        .N_OUT      (N_OUT),
        .IDCODE_VAL (IDV)
    ) dut (
        .TCK      (TCK),
        .TRST     (TRST),
        .TMS      (TMS),
        .TDI      (TDI),
        .TDO      (TDO),
        .TDO_EN   (TDO_EN),
        .STATE    (STATE),
        .sys_in   (sys_in),
        .core_in  (core_in),
        .core_out (core_out),
        .sys_out  (sys_out)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Next-state table indexed [state][tms], straight from the 1149.1 state diagram.
    int nxt [16][2] = '{
        '{1, 0}, '{1, 2}, '{3, 9}, '{4, 5}, '{4, 5}, '{6, 8}, '{6, 7}, '{4, 8},
        '{1, 2}, '{10, 0}, '{11, 12}, '{11, 12}, '{13, 15}, '{13, 14}, '{11, 15}, '{1, 2}
    };

    int          m_state = 0;
    int          m_ir = 2;
    bit          irq[$];
    bit          drq[$];
    logic [5:0]  m_latch = '0;
    logic [31:0] idv_v = IDV;

    // 0 EXTEST, 1 SAMPLE, 2 IDCODE, 3 INTEST, 4 BYPASS
    function automatic int kind(input int ir);
        case (ir)
            0: return 0;
            1: return 1;
            2: return 2;
            3: return 3;
            default: return 4;
        endcase
    endfunction

    always @(posedge TCK) begin
        int k;
        if (TRST) begin
            m_state = 0;
            m_ir = 2;
            m_latch = '0;
            irq.delete();
            drq.delete();
        end else begin
            k = kind(m_ir);
            case (m_state)
                10: begin
                    irq.delete();
                    irq.push_back(1'b1);
                    for (int i = 1; i < IR_W; i++) irq.push_back(1'b0);
                end
                11: begin
                    void'(irq.pop_front());
                    irq.push_back(TDI);
                end
                15: begin
                    m_ir = 0;
                    for (int i = 0; i < IR_W; i++) m_ir += int'(irq[i]) << i;
                end
                3: begin
                    drq.delete();
                    if (k == 4) drq.push_back(1'b0);
                    else if (k == 2) for (int i = 0; i < 32; i++) drq.push_back(idv_v[i]);
                    else begin
                        for (int i = 0; i < N_IN; i++) drq.push_back(sys_in[i]);
                        for (int i = 0; i < N_OUT; i++) drq.push_back(core_out[i]);
                    end
                end
                4: begin
                    void'(drq.pop_front());
                    drq.push_back(TDI);
                end
                8: if (k != 2 && k != 4) for (int i = 0; i < 6; i++) m_latch[i] = drq[i];
                default: ;
            endcase
            m_state = nxt[m_state][TMS ? 1 : 0];
            if (m_state == 0) m_ir = 2;
        end
    end

    always @(negedge TCK) begin
        int   k;
        logic e_tdo;
        logic [3:0] e_core_in;
        logic [1:0] e_sys_out;
        if (chk_en) begin
            k = kind(m_ir);
            e_tdo = 1'b0;
            if (m_state == 4 && drq.size() > 0) e_tdo = drq[0];
            if (m_state == 11 && irq.size() > 0) e_tdo = irq[0];
            e_core_in = (k == 3) ? m_latch[3:0] : sys_in;
            e_sys_out = (k == 0 || k == 3) ? m_latch[5:4] : core_out;
            check("state", 64'(STATE), 64'(m_state));
            check("tdo_en", 64'(TDO_EN), 64'(m_state == 4 || m_state == 11));
            check("tdo", 64'(TDO), 64'(e_tdo));
            check("core_in", 64'(core_in), 64'(e_core_in));
            check("sys_out", 64'(sys_out), 64'(e_sys_out));
        end
    end

    task automatic step(input logic tms, input logic tdi, output logic tdo);
        @(negedge TCK);
        #1;
        TMS = tms;
        TDI = tdi;
        tdo = TDO;
        @(posedge TCK);
    endtask

    task automatic go(input logic tms);
        logic d;
        step(tms, 1'b0, d);
    endtask

    task automatic scan_dr(input logic [63:0] din, input int n, output logic [63:0] dout);
        logic b;
        dout = '0;
        go(1'b1); go(1'b0); go(1'b0);
        for (int i = 0; i < n; i++) begin
            step(i == n - 1, din[i], b);
            dout[i] = b;
        end
        go(1'b1); go(1'b0);
    endtask

    task automatic load_ir(input logic [3:0] op, output logic [3:0] cap);
        logic b;
        go(1'b1); go(1'b1); go(1'b0); go(1'b0);
        for (int i = 0; i < IR_W; i++) begin
            step(i == IR_W - 1, op[i], b);
            cap[i] = b;
        end
        go(1'b1); go(1'b0);
    endtask

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout: got running expected finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        logic [63:0] d;
        logic [3:0]  cap;
        logic        b;

        repeat (2) @(posedge TCK);
        #1;
        check("rst_state", 64'(STATE), 64'(0));
        check("rst_tdo", 64'(TDO), 64'(0));
        check("rst_tdo_en", 64'(TDO_EN), 64'(0));
        check("rst_core_in", 64'(core_in), 64'(4'b0110));
        check("rst_sys_out", 64'(sys_out), 64'(2'b01));
        @(negedge TCK);
        chk_en = 1'b1;
        #1;
        TRST = 1'b0;
        @(posedge TCK);

        go(1'b0);
        scan_dr(64'd0, 32, d);
        check("idcode_scan", 64'(d[31:0]), 64'(32'h1234_5001));

        // IDCODE scan interrupted by a two-cycle pause after four bits.
        go(1'b1); go(1'b0); go(1'b0);
        d = '0;
        for (int i = 0; i < 32; i++) begin
            step(i == 3 || i == 31, 1'b0, b);
            d[i] = b;
            if (i == 3) begin
                go(1'b0); go(1'b0); go(1'b1); go(1'b0);
            end
        end
        go(1'b1); go(1'b0);
        check("idcode_pause", 64'(d[31:0]), 64'(32'h1234_5001));

        load_ir(4'b1111, cap);
        check("ir_capture", 64'(cap), 64'(4'b0001));
        scan_dr(64'hAA, 8, d);
        check("bypass_scan", 64'(d[7:0]), 64'(8'b0101_0100));

        go(1'b1); go(1'b1); go(1'b0); go(1'b0);
        step(1'b0, 1'b1, b);
        repeat (5) go(1'b1);
        #1;
        check("tms5_state", 64'(STATE), 64'(0));
        go(1'b0);
        scan_dr(64'd0, 32, d);
        check("tms5_idcode", 64'(d[31:0]), 64'(32'h1234_5001));

        sys_in = 4'b1011;
        core_out = 2'b10;
        load_ir(4'b0001, cap);
        scan_dr(64'd0, 6, d);
        check("sample_scan", 64'(d[5:0]), 64'(6'b10_1011));

        load_ir(4'b0000, cap);
        scan_dr(64'b01_0000, 6, d);
        #1;
        check("extest_sys_out", 64'(sys_out), 64'(2'b01));
        core_out = 2'b11;
        #1;
        check("extest_hold", 64'(sys_out), 64'(2'b01));
        check("extest_core_in", 64'(core_in), 64'(4'b1011));

        load_ir(4'b0101, cap);
        scan_dr(64'hFF, 8, d);
        check("undef_bypass", 64'(d[7:0]), 64'(8'b1111_1110));

        load_ir(4'b0011, cap);
        scan_dr(64'b10_0101, 6, d);
        #1;
        check("intest_core_in", 64'(core_in), 64'(4'b0101));
        check("intest_sys_out", 64'(sys_out), 64'(2'b10));
        go(1'b1); go(1'b0); go(1'b0);
        step(1'b0, 1'b1, b);
        step(1'b0, 1'b0, b);
        @(negedge TCK);
        #1;
        TRST = 1'b1;
        @(posedge TCK);
        #1;
        check("trst_state", 64'(STATE), 64'(0));
        check("trst_sys_out", 64'(sys_out), 64'(2'b11));
        check("trst_core_in", 64'(core_in), 64'(4'b1011));
        check("trst_tdo_en", 64'(TDO_EN), 64'(0));
        @(negedge TCK);
        #1;
        TRST = 1'b0;
        repeat (2) go(1'b1);

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/jtag_tap_param.md
JTAG_TAP_PARAM -- requirements
Module: jtag_tap_param

Interface
REQ-001 Parameter IR_W, default 4, instruction register length (>=2).
REQ-002 Parameter N_IN, default 4, number of boundary input cells.
REQ-003 Parameter N_OUT, default 2, number of boundary output cells.
REQ-004 Parameter IDCODE_VAL, default 32'h1234_5001, device ID; bit 0 SHALL be 1.
REQ-005 TCK  in  1  sole clock; all state changes on rising edge.
REQ-006 TRST  in  1  reset, synchronous, active-high.
REQ-007 TMS  in  1  TAP mode select.
REQ-008 TDI  in  1  serial data in.
REQ-009 TDO  out  1  serial data out.
REQ-010 TDO_EN  out  1  high while in SHIFT_DR or SHIFT_IR.
REQ-011 STATE  out  4  current TAP state code.
REQ-012 sys_in  in  N_IN  pin-side inputs.
REQ-013 core_in  out  N_IN  core-side copy of inputs.
REQ-014 core_out  in  N_OUT  core-side outputs.
REQ-015 sys_out  out  N_OUT  pin-side outputs.

Function
REQ-016 FSM SHALL implement the 16 IEEE 1149.1 TAP states, coded 0 TEST_LOGIC_RESET, 1 RUN_TEST_IDLE, 2 SELECT_DR_SCAN, 3 CAPTURE_DR, 4 SHIFT_DR, 5 EXIT1_DR, 6 PAUSE_DR, 7 EXIT2_DR, 8 UPDATE_DR, 9 SELECT_IR_SCAN, 10 CAPTURE_IR, 11 SHIFT_IR, 12 EXIT1_IR, 13 PAUSE_IR, 14 EXIT2_IR, 15 UPDATE_IR, with standard TMS transitions.
REQ-017 Five consecutive TCK edges with TMS=1 SHALL reach TEST_LOGIC_RESET from any state.
REQ-018 Opcodes: EXTEST = all 0; SAMPLE = 1; IDCODE = 2; INTEST = 3; BYPASS = all 1; any other value SHALL decode as BYPASS.
REQ-019 CAPTURE_IR SHALL load the IR shift stage with {0..0,2'b01}; SHIFT_IR shifts right, TDI into MSB, TDO = bit 0.
REQ-020 UPDATE_IR SHALL copy the IR shift stage into the active IR; the active IR SHALL change at no other time except reset.
REQ-021 Entering TEST_LOGIC_RESET SHALL set the active IR to IDCODE.
REQ-022 Selected DR: BYPASS -> 1-bit bypass; IDCODE -> 32-bit ID; EXTEST/SAMPLE/INTEST -> boundary register (BSR), length N_IN+N_OUT, bits [N_IN-1:0] input cells, upper bits output cells.
REQ-023 CAPTURE_DR: bypass <= 0; ID register <= IDCODE_VAL; BSR <= {core_out, sys_in}.
REQ-024 SHIFT_DR: selected register shifts right one bit per TCK, TDI into MSB, TDO = bit 0; unselected registers hold.
REQ-025 UPDATE_DR with EXTEST, SAMPLE or INTEST SHALL copy the BSR shift stage into the BSR update latch; BYPASS/IDCODE leave the latch unchanged.
REQ-026 Pass-through: SAMPLE/IDCODE/BYPASS SHALL drive core_in = sys_in, sys_out = core_out combinationally.
REQ-027 EXTEST: sys_out = latch[N_IN+N_OUT-1:N_IN]; core_in = sys_in.
REQ-028 INTEST: core_in = latch[N_IN-1:0]; sys_out = latch output cells.
REQ-029 Outside SHIFT states, TDO SHALL be 0 and TDO_EN 0; PAUSE states hold all shift stages.
REQ-030 TMS is sampled only on the TCK rising edge; TDI is sampled on that same edge in SHIFT states.

Reset
REQ-031 TRST=1 at a TCK edge SHALL force STATE=0, active IR=IDCODE, IR/DR shift stages and BSR latch to 0, bypass to 0, overriding any in-progress scan.
REQ-032 Reset values: TDO=0, TDO_EN=0, STATE=0, core_in=sys_in, sys_out=core_out.

Structure
REQ-033 A shared package SHALL hold the 4-bit state codes and the opcode constants (width-parametrised by IR_W).
REQ-034 The TAP state machine SHALL be a sub-module jtag_tap_fsm (TCK, TRST, TMS -> STATE plus one-hot capture/shift/update strobes).

Verification
REQ-035 TRST pulse, then 32 SHIFT_DR cycles with TDI=0 -> TDO sequence LSB-first = 32'h1234_5001.
REQ-036 Load BYPASS (4'b1111), shift DR 8'b10101010 -> TDO = 0 followed by TDI delayed one cycle.
REQ-037 From SHIFT_IR, any state with TMS=1 for 5 cycles -> STATE=0, IR=IDCODE.
REQ-038 SAMPLE with sys_in=4'b1011, core_out=2'b10 -> first 6 TDO bits = 1,1,0,1,0,1.
REQ-039 EXTEST, shift 6'b01_0000, UPDATE_DR -> sys_out=2'b01, independent of core_out.
REQ-040 Assert TRST mid-SHIFT_DR under INTEST -> next edge STATE=0, sys_out=core_out, core_in=sys_in.
